// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer for a multicycle core: detects undef/ovf/irq,
// saves the return address through r26, redirects the PC and tracks handler mode.
module exception_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic        instr_done_i,
  input  logic        undef_i,
  input  logic        ovf_i,
  input  logic        eret_i,
  input  logic        irq_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] npc_i,
  output logic        flush_o,
  output logic        ErrorTargetWrite,
  output logic [4:0]  ErrorTarget_o,
  output logic [31:0] epc_o,
  output logic        pc_write_o,
  output logic [31:0] pc_next_o,
  output logic [1:0]  cause_o,
  output logic        kernel_o,
  output logic        nested_err_o
);

  localparam logic [2:0]  STAGE_ID  = 3'd1;
  localparam logic [2:0]  STAGE_EX  = 3'd2;
  localparam logic [4:0]  ERR_REG   = 5'd26;
  localparam logic [31:0] VEC_IRQ   = 32'h8000_0004;
  localparam logic [31:0] VEC_EXC   = 32'h8000_0008;
  localparam logic [1:0]  C_NONE    = 2'd0;
  localparam logic [1:0]  C_IRQ     = 2'd1;
  localparam logic [1:0]  C_UNDEF   = 2'd2;
  localparam logic [1:0]  C_OVF     = 2'd3;

  typedef enum logic [1:0] {RUN, SAVE, JUMP, KERNEL} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, irq_pend_q;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        kernel_q, kernel_d;
  logic        nested_q, nested_d;
  logic        armed_q, armed_d;

  logic ev_undef, ev_ovf, ev_irq;

  assign ev_undef = (stage_i == STAGE_ID) && undef_i;
  assign ev_ovf   = (stage_i == STAGE_EX) && ovf_i;
  assign ev_irq   = instr_done_i && irq_pend_q;

  // Two-flop level synchronizer for the asynchronous interrupt line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      sync1_q    <= irq_i;
      irq_pend_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      epc_q    <= 32'd0;
      cause_q  <= C_NONE;
      kernel_q <= 1'b0;
      nested_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      kernel_q <= kernel_d;
      nested_q <= nested_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    kernel_d         = kernel_q;
    nested_d         = nested_q;
    armed_d          = armed_q;
    flush_o          = 1'b0;
    ErrorTargetWrite = 1'b0;
    pc_write_o       = 1'b0;
    pc_next_o        = 32'd0;
    case (state_q)
      RUN: begin
        // Faults skip the offending instruction; irq lets it retire
        if (ev_undef) begin
          flush_o = 1'b1;
          epc_d   = pc_i + 32'd4;
          cause_d = C_UNDEF;
          state_d = SAVE;
        end else if (ev_ovf) begin
          flush_o = 1'b1;
          epc_d   = pc_i + 32'd4;
          cause_d = C_OVF;
          state_d = SAVE;
        end else if (ev_irq) begin
          epc_d   = npc_i;
          cause_d = C_IRQ;
          state_d = SAVE;
        end
      end
      SAVE: begin
        ErrorTargetWrite = 1'b1;
        flush_o          = 1'b1;
        state_d          = JUMP;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_next_o  = (cause_q == C_IRQ) ? VEC_IRQ : VEC_EXC;
        flush_o    = 1'b1;
        kernel_d   = 1'b1;
        state_d    = KERNEL;
      end
      KERNEL: begin
        // Interrupts stay masked; faults only flag and flush
        if (ev_undef || ev_ovf) begin
          nested_d = 1'b1;
          flush_o  = 1'b1;
        end
        if (eret_i && (stage_i == STAGE_ID)) armed_d = 1'b1;
        if (armed_q && instr_done_i) begin
          armed_d  = 1'b0;
          kernel_d = 1'b0;
          cause_d  = C_NONE;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign ErrorTarget_o = ERR_REG;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;
  assign kernel_o      = kernel_q;
  assign nested_err_o  = nested_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: expected trap records are queued at the
// detecting stimulus and popped when the save/jump strobes appear.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  stage_i;
  logic        instr_done_i, undef_i, ovf_i, eret_i, irq_i;
  logic [31:0] pc_i, npc_i;
  logic        flush_o, ErrorTargetWrite, pc_write_o, kernel_o, nested_err_o;
  logic [4:0]  ErrorTarget_o;
  logic [31:0] epc_o, pc_next_o;
  logic [1:0]  cause_o;

  typedef struct {
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] target;
  } trap_t;

  trap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  exception_ctrl dut (
    .clk(clk), .reset(reset), .stage_i(stage_i), .instr_done_i(instr_done_i),
    .undef_i(undef_i), .ovf_i(ovf_i), .eret_i(eret_i), .irq_i(irq_i),
    .pc_i(pc_i), .npc_i(npc_i), .flush_o(flush_o),
    .ErrorTargetWrite(ErrorTargetWrite), .ErrorTarget_o(ErrorTarget_o),
    .epc_o(epc_o), .pc_write_o(pc_write_o), .pc_next_o(pc_next_o),
    .cause_o(cause_o), .kernel_o(kernel_o), .nested_err_o(nested_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stage_i = 3'd0; instr_done_i = 1'b0; undef_i = 1'b0;
    ovf_i = 1'b0; eret_i = 1'b0; pc_i = 32'h0040_0000; npc_i = 32'h0040_0004;
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [1:0] cause,
                           input logic [31:0] target);
    trap_t t;
    t.epc = epc; t.cause = cause; t.target = target;
    exp_q.push_back(t);
  endtask

  // Waits (bounded) for SAVE, then checks SAVE, JUMP and KERNEL entry.
  task automatic expect_trap(input string tag);
    trap_t t;
    int i;
    i = 0;
    while (!ErrorTargetWrite && i < 4) begin
      next_cycle();
      i++;
    end
    chk({tag, "_save_seen"}, 32'(ErrorTargetWrite), 32'd1);
    chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      t = exp_q.pop_front();
      chk({tag, "_epc"}, epc_o, t.epc);
      chk({tag, "_cause"}, 32'(cause_o), 32'(t.cause));
      chk({tag, "_save_flush"}, 32'(flush_o), 32'd1);
      chk({tag, "_save_pcw"}, 32'(pc_write_o), 32'd0);
      next_cycle();
      chk({tag, "_jump_pcw"}, 32'(pc_write_o), 32'd1);
      chk({tag, "_jump_target"}, pc_next_o, t.target);
      chk({tag, "_jump_etw"}, 32'(ErrorTargetWrite), 32'd0);
      chk({tag, "_jump_flush"}, 32'(flush_o), 32'd1);
      next_cycle();
      chk({tag, "_kernel"}, 32'(kernel_o), 32'd1);
      chk({tag, "_kern_pcw"}, 32'(pc_write_o), 32'd0);
      chk({tag, "_kern_etw"}, 32'(ErrorTargetWrite), 32'd0);
      chk({tag, "_kern_cause"}, 32'(cause_o), 32'(t.cause));
    end
  endtask

  task automatic do_eret(input string tag, input logic [31:0] held_epc);
    @(negedge clk); stage_i = 3'd1; eret_i = 1'b1;
    @(negedge clk); eret_i = 1'b0; stage_i = 3'd4; instr_done_i = 1'b1; #1;
    chk({tag, "_eret_done_flush"}, 32'(flush_o), 32'd0);
    chk({tag, "_eret_kernel_hold"}, 32'(kernel_o), 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk({tag, "_ret_kernel"}, 32'(kernel_o), 32'd0);
    chk({tag, "_ret_cause"}, 32'(cause_o), 32'd0);
    chk({tag, "_ret_epc_hold"}, epc_o, held_epc);
    chk({tag, "_ret_etw"}, 32'(ErrorTargetWrite), 32'd0);
  endtask

  initial begin
    idle_inputs();
    irq_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_etw", 32'(ErrorTargetWrite), 32'd0);
    chk("rst_et", 32'(ErrorTarget_o), 32'd26);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_pcw", 32'(pc_write_o), 32'd0);
    chk("rst_pcn", pc_next_o, 32'd0);
    chk("rst_cause", 32'(cause_o), 32'd0);
    chk("rst_kernel", 32'(kernel_o), 32'd0);
    chk("rst_nested", 32'(nested_err_o), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Undefined opcode trap
    @(negedge clk); stage_i = 3'd1; undef_i = 1'b1; pc_i = 32'h0040_0010; #1;
    chk("undef_flush", 32'(flush_o), 32'd1);
    push_trap(32'h0040_0014, 2'd2, 32'h8000_0008);
    @(negedge clk); idle_inputs(); #1;
    expect_trap("undef");
    do_eret("undef", 32'h0040_0014);

    // Interrupt at instruction boundary after synchronizer latency
    @(negedge clk); irq_i = 1'b1;
    repeat (3) @(negedge clk);
    instr_done_i = 1'b1; npc_i = 32'h0040_0100; stage_i = 3'd4; #1;
    chk("irq_flush", 32'(flush_o), 32'd0);
    push_trap(32'h0040_0100, 2'd1, 32'h8000_0004);
    @(negedge clk); idle_inputs(); irq_i = 1'b0; #1;
    expect_trap("irq");
    do_eret("irq", 32'h0040_0100);

    // Simultaneous undef/ovf/irq: undef wins, irq stays held
    @(negedge clk); irq_i = 1'b1;
    repeat (3) @(negedge clk);
    stage_i = 3'd1; undef_i = 1'b1; ovf_i = 1'b1; instr_done_i = 1'b1;
    pc_i = 32'h0040_0200; #1;
    chk("prio_flush", 32'(flush_o), 32'd1);
    push_trap(32'h0040_0204, 2'd2, 32'h8000_0008);
    @(negedge clk); idle_inputs(); #1;
    expect_trap("prio");

    // Nested overflow in kernel, masked irq
    @(negedge clk); stage_i = 3'd2; ovf_i = 1'b1; #1;
    chk("nest_flush", 32'(flush_o), 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk("nest_flag", 32'(nested_err_o), 32'd1);
    chk("nest_kernel", 32'(kernel_o), 32'd1);
    chk("nest_etw", 32'(ErrorTargetWrite), 32'd0);
    @(negedge clk); instr_done_i = 1'b1; stage_i = 3'd4; #1;
    chk("mask_flush", 32'(flush_o), 32'd0);
    @(negedge clk); idle_inputs(); #1;
    chk("mask_etw", 32'(ErrorTargetWrite), 32'd0);
    chk("mask_cause", 32'(cause_o), 32'd2);
    do_eret("nest", 32'h0040_0204);
    next_cycle();
    chk("held_wait_etw", 32'(ErrorTargetWrite), 32'd0);
    chk("nest_sticky", 32'(nested_err_o), 32'd1);
    @(negedge clk); instr_done_i = 1'b1; stage_i = 3'd4; npc_i = 32'h0040_0300; #1;
    chk("held_flush", 32'(flush_o), 32'd0);
    push_trap(32'h0040_0300, 2'd1, 32'h8000_0004);
    @(negedge clk); idle_inputs(); irq_i = 1'b0; #1;
    expect_trap("held");
    do_eret("held", 32'h0040_0300);

    // pc+4 wraps to zero
    @(negedge clk); stage_i = 3'd1; undef_i = 1'b1; pc_i = 32'hFFFF_FFFC; #1;
    push_trap(32'h0000_0000, 2'd2, 32'h8000_0008);
    @(negedge clk); idle_inputs(); #1;
    expect_trap("wrap");
    do_eret("wrap", 32'h0000_0000);

    // Reset in JUMP aborts the trap
    @(negedge clk); stage_i = 3'd2; ovf_i = 1'b1; pc_i = 32'h0040_0030;
    @(negedge clk); idle_inputs();
    @(negedge clk); #1;
    chk("abort_in_jump", 32'(pc_write_o), 32'd1);
    reset = 1'b1; #1;
    chk("abort_pcw", 32'(pc_write_o), 32'd0);
    chk("abort_kernel", 32'(kernel_o), 32'd0);
    chk("abort_nested", 32'(nested_err_o), 32'd0);
    chk("abort_cause", 32'(cause_o), 32'd0);
    chk("abort_epc", epc_o, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      next_cycle();
      chk("post_abort_pcw", 32'(pc_write_o), 32'd0);
      chk("post_abort_etw", 32'(ErrorTargetWrite), 32'd0);
      chk("post_abort_kernel", 32'(kernel_o), 32'd0);
    end

    // Fresh overflow trap from RUN after the abort
    @(negedge clk); stage_i = 3'd2; ovf_i = 1'b1; pc_i = 32'h0040_0040; #1;
    chk("ovf_flush", 32'(flush_o), 32'd1);
    push_trap(32'h0040_0044, 2'd3, 32'h8000_0008);
    @(negedge clk); idle_inputs(); #1;
    expect_trap("ovf");
    do_eret("ovf", 32'h0040_0044);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have reset: reset, asynchronous, active-high; clock: clk.
REQ-002 The block SHALL have the following ports (name direction width meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- stage_i  in  3  multicycle stage: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
- instr_done_i  in  1  last cycle of current instruction
- undef_i  in  1  undefined opcode; meaningful only when stage_i=1
- ovf_i  in  1  ALU signed overflow; meaningful only when stage_i=2
- eret_i  in  1  return-from-handler decoded; meaningful only when stage_i=1
- irq_i  in  1  external interrupt, asynchronous level
- pc_i  in  32  address of current instruction
- npc_i  in  32  next PC computed by datapath; valid with instr_done_i
- flush_o  out  1  abort current instruction; suppress reg/mem writes
- ErrorTargetWrite  out  1  write strobe toward the error-target register
- ErrorTarget_o  out  5  register index for the saved return address
- epc_o  out  32  return address for register-file write
- pc_write_o  out  1  force PC load
- pc_next_o  out  32  forced PC value
- cause_o  out  2  0 none, 1 irq, 2 undef, 3 ovf
- kernel_o  out  1  handler mode
- nested_err_o  out  1  sticky: exception raised while in kernel

Function
REQ-003 FSM states SHALL be RUN, SAVE, JUMP, KERNEL.
REQ-004 irq_i SHALL pass through a 2-flop synchronizer; irq_pend is the synchronized level, with no edge latching.
REQ-005 In RUN, an event SHALL be detected combinationally: undef (stage_i=1 & undef_i), ovf (stage_i=2 & ovf_i), irq (instr_done_i & irq_pend).
REQ-006 Priority SHALL be undef > ovf > irq. Only one event is accepted per cycle.
REQ-007 On undef or ovf detection, flush_o SHALL be 1 in the same cycle. The captured return address is pc_i+4, so the faulting instruction is skipped.
REQ-008 On irq detection, flush_o SHALL stay 0 so the instruction completes. The captured return address is npc_i.
REQ-009 On any detection, the block SHALL register the return address and cause, then move RUN->SAVE on the next edge.
REQ-010 SAVE (1 cycle) SHALL drive:
- ErrorTargetWrite=1
- ErrorTarget_o=5'd26
- epc_o=captured return address
- flush_o=1
Next state is JUMP.
REQ-011 JUMP (1 cycle) SHALL drive:
- pc_write_o=1
- pc_next_o=32'h80000004 for irq, 32'h80000008 for undef/ovf
- flush_o=1
kernel_o is set on the JUMP->KERNEL edge.
REQ-012 In KERNEL, irq SHALL be masked; irq_pend stays pending and is re-evaluated after return.
REQ-013 In KERNEL, undef/ovf SHALL set nested_err_o, assert flush_o for that cycle, and cause no state change.
REQ-014 In KERNEL, eret_i at stage_i=1 SHALL arm a return. At the next instr_done_i the block SHALL clear kernel_o and cause_o and return to RUN.
REQ-015 An irq SHALL NOT be accepted in the same cycle as the eret instruction's instr_done_i. It is first eligible at the next instruction boundary in RUN.
REQ-016 Outside SAVE and JUMP, ErrorTargetWrite and pc_write_o SHALL be 0. ErrorTarget_o SHALL hold 5'd26 at all times.
REQ-017 epc_o SHALL hold the last captured value until the next capture.
REQ-018 pc_i+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-019 cause_o SHALL be valid from SAVE until return to RUN.

Reset
REQ-020 On reset the block SHALL asynchronously force:
- state RUN
- all outputs 0, except ErrorTarget_o=26
- synchronizer flops, armed-eret flag, captured address and nested_err_o cleared
REQ-021 Reset during SAVE or JUMP SHALL abort the trap with no further strobes after deassertion.

Verification
REQ-022 undef_i=1, stage_i=1, pc_i=0x00400010:
- flush_o=1 in that cycle
- next cycle: ErrorTargetWrite=1, epc_o=0x00400014, cause_o=2
- then pc_write_o=1, pc_next_o=0x80000008, then kernel_o=1
REQ-023 irq_i raised; after 2 syncs, instr_done_i=1, npc_i=0x00400100:
- flush_o=0
- SAVE: epc_o=0x00400100, cause_o=1
- JUMP: pc_next_o=0x80000004
REQ-024 undef_i, ovf_i and irq all active in the same cycle (stage_i=1 for undef) -> cause_o=2 and a single trap.
REQ-025 In KERNEL, ovf_i at stage_i=2 -> nested_err_o=1 and the state stays KERNEL. Held irq_i is not taken. eret_i then instr_done_i -> RUN; the held irq is taken at the next boundary.
REQ-026 pc_i=0xFFFFFFFC with undef -> epc_o=0x00000000.
REQ-027 Reset asserted during JUMP -> pc_write_o=0 immediately, kernel_o=0, state RUN.
